dvi_in_capture: RTL and testbench
=================================

DVI_IN_CAPTURE -- requirements
Module: dvi_in_capture

Interface
REQ-001 Parameter SYNC_ACT_HIGH, default 1: 1 means iHsync/iVsync active-high; 0 means active-low.
REQ-002 Parameter CNT_W, default 12: width of the X, Y, width and height counters.
REQ-003 iClk_0  in  1  sole clock; all logic is on the rising edge.
REQ-004 iRst_n  in  1  reset, asynchronous, active-low.
REQ-005 iData  in  12  half-pixel word from the DVI link.
REQ-006 iHsync  in  1  horizontal sync.
REQ-007 iVsync  in  1  vertical sync.
REQ-008 iDe  in  1  data enable.
REQ-009 oPixel  out  24  assembled pixel.
REQ-010 oPixelValid  out  1  one-cycle strobe marking oPixel valid.
REQ-011 oX, oY  out  CNT_W each  coordinates of the current oPixel.
REQ-012 oSof  out  1  asserted with the pixel at X=0, Y=0.
REQ-013 oEol  out  1  one-cycle pulse after the last pixel of a line.
REQ-014 oLineWidth, oFrameHeight  out  CNT_W each  pixels per line and lines per frame, as measured.
REQ-015 oLocked  out  1  stable-timing flag.
REQ-016 oError  out  1  sticky odd-word error flag.

Function
REQ-017 Input registration: iData, iHsync, iVsync and iDe SHALL each be registered once before use. All sync edges refer to these registered copies.
REQ-018 Sync normalisation: vsync-active SHALL mean registered iVsync == SYNC_ACT_HIGH. Hsync is registered but not used for timing.
REQ-019 FSM states:
- S_SEARCH: entered on reset. No pixels are emitted.
- S_FRAME: entered on the first vsync-active rising edge.
REQ-020 S_FRAME is left only by reset.
REQ-021 Half-word phase:
- The phase bit SHALL clear on every registered-De rising edge.
- While De is high, the phase bit toggles each cycle.
- Phase 0 stores the word in a low holding register.
- Phase 1 forms the pixel as {word, hold}, i.e. the first word is bits [11:0].
REQ-022 Latency: when the phase-1 word is on iData in cycle n, oPixelValid SHALL be high in cycle n+2, with oPixel, oX, oY and oSof valid in the same cycle.
REQ-023 oPixelValid SHALL assert only in S_FRAME.
REQ-024 X counter: oX SHALL be 0 for the first pixel of each line and increment by 1 per pixel. It saturates at all-ones and does not wrap.
REQ-025 Y counter:
- oY SHALL increment on each registered-De falling edge in S_FRAME.
- It resets to 0 on a vsync-active rising edge.
- It saturates at all-ones.
REQ-026 oSof SHALL equal oPixelValid AND oX==0 AND oY==0.
REQ-027 oEol SHALL pulse for exactly one cycle, one cycle after the last oPixelValid of a line.
REQ-028 Odd word count: if De falls while the phase bit is 1 (the last word is unpaired), then:
- the unpaired word SHALL be discarded;
- oError SHALL set and stay set until reset;
- oEol still pulses.
REQ-029 Line width: the line's pixel count SHALL be latched internally on each De falling edge.
REQ-030 Frame measurement: on each vsync-active rising edge in S_FRAME:
- oLineWidth SHALL load the width of the last line;
- oFrameHeight SHALL load the line count of the frame.
REQ-031 oLocked:
- SHALL set when a newly loaded width/height pair is non-zero and equal to the previous pair.
- SHALL clear whenever the pair differs.
REQ-032 Vsync during an active line (De high): the line SHALL be aborted, with no oEol, and the Y counter resets. The first De rising edge after that restarts at X=0, Y=0.
REQ-033 Simultaneous events: if a De falling edge and a vsync-active edge occur in the same cycle, the vsync action SHALL win for Y, and the line-end width latch still occurs.

Reset
REQ-034 While iRst_n is low, all outputs and internal registers SHALL be 0, including oPixel, oLocked and oError, and the FSM SHALL be in S_SEARCH.
REQ-035 Reset SHALL take effect asynchronously. Release is sampled on the next clock edge.
REQ-036 After release, no pixel SHALL be emitted before the first vsync-active rising edge.
REQ-037 Reset asserted mid-line SHALL discard any partial pixel.

Verification
REQ-038 Reset: hold iRst_n low for 5 cycles with random inputs. Required: all outputs 0; oPixelValid stays 0 until a vsync edge is seen.
REQ-039 Basic frame: vsync pulse, then 2 lines of 8 words each. Word values are 0x001, 0x002, … in order.
- The first pixel SHALL be 0x002001 with oSof=1.
- There SHALL be 4 pixels per line and two oEol pulses.
- At the next vsync: oLineWidth=4, oFrameHeight=2.
REQ-040 Lock: three identical 4x2 frames SHALL give oLocked=1 after the second vsync edge that closes a frame. A fourth frame of 5x2 SHALL clear oLocked.
REQ-041 Odd De: a line of 7 words SHALL give 3 pixels, oError=1, and one oEol. oError SHALL remain 1 over the following frames.
REQ-042 Mid-line disruptions:
- Vsync asserted after 4 words of a line: no oEol for that line, and the next line starts at X=0, Y=0.
- iRst_n pulsed low mid-line: outputs SHALL be 0 asynchronously, and the bench checks that REQ-036 holds afterwards.

Source files
------------

// File: rtl/dvi_in_capture_if.sv
// DVI capture bus: half-pixel link inputs and assembled pixel outputs.
// Ports: link (iData/iHsync/iVsync/iDe) in, pixel/timing/status out.
interface dvi_in_capture_if #(
    parameter int CNT_W = 12
);
    logic [11:0]      iData;
    logic             iHsync;
    logic             iVsync;
    logic             iDe;
    logic [23:0]      oPixel;
    logic             oPixelValid;
    logic [CNT_W-1:0] oX;
    logic [CNT_W-1:0] oY;
    logic             oSof;
    logic             oEol;
    logic [CNT_W-1:0] oLineWidth;
    logic [CNT_W-1:0] oFrameHeight;
    logic             oLocked;
    logic             oError;

    modport master (
        output iData, iHsync, iVsync, iDe,
        input  oPixel, oPixelValid, oX, oY, oSof, oEol,
        input  oLineWidth, oFrameHeight, oLocked, oError
    );

    modport slave (
        input  iData, iHsync, iVsync, iDe,
        output oPixel, oPixelValid, oX, oY, oSof, oEol,
        output oLineWidth, oFrameHeight, oLocked, oError
    );
endinterface

// File: rtl/dvi_in_capture.sv
// DVI input capture: pairs 12-bit half words into 24-bit pixels, tracks X/Y.
// Ports: iClk_0, iRst_n (async, active-low), bus (dvi_in_capture_if.slave).
module dvi_in_capture #(
    parameter bit SYNC_ACT_HIGH = 1'b1,
    parameter int CNT_W         = 12
) (
    input  logic              iClk_0,
    input  logic              iRst_n,
    dvi_in_capture_if.slave   bus
);
    typedef enum logic {
        S_SEARCH,
        S_FRAME
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t state_q;
    state_t state_d;

    logic [11:0] d_r;
    logic        hs_r;
    logic        vs_r;
    logic        de_r;
    logic        de_q;
    logic        vs_q;

    logic        vs_rise;
    logic        de_rise;
    logic        de_fall;
    logic        in_frame;
    logic        ph_eff;
    logic        abort_now;
    logic        emit;
    logic        line_end;
    logic        meas;

    logic             phase;
    logic [11:0]      hold;
    logic             abort;
    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_cnt;
    logic [CNT_W-1:0] width_lat;
    logic [CNT_W-1:0] w_new;
    logic [CNT_W-1:0] h_new;

    logic [23:0]      pixel_q;
    logic             valid_q;
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] y_q;
    logic             sof_q;
    logic             eol_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] height_q;
    logic             locked_q;
    logic             error_q;

    // Hsync is captured with the other link inputs but carries no timing.
    logic unused_hsync;
    assign unused_hsync = hs_r;

    // vs_r holds the normalised (1 = active) vsync so reset means inactive.
    always_ff @(posedge iClk_0 or negedge iRst_n) begin
        if (!iRst_n) begin
            d_r  <= '0;
            hs_r <= 1'b0;
            vs_r <= 1'b0;
            de_r <= 1'b0;
            de_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            d_r  <= bus.iData;
            hs_r <= bus.iHsync;
            vs_r <= (bus.iVsync == SYNC_ACT_HIGH);
            de_r <= bus.iDe;
            de_q <= de_r;
            vs_q <= vs_r;
        end
    end

    assign vs_rise   = vs_r & ~vs_q;
    assign de_rise   = de_r & ~de_q;
    assign de_fall   = ~de_r & de_q;
    assign in_frame  = (state_q == S_FRAME);
    assign ph_eff    = de_rise ? 1'b0 : phase;
    assign abort_now = vs_rise & de_r;
    assign emit      = in_frame & de_r & ph_eff & ~abort & ~abort_now;
    assign line_end  = in_frame & de_fall & ~abort;
    assign meas      = in_frame & vs_rise;

    // A line ending in the same cycle as vsync still counts toward the frame.
    assign w_new = de_fall ? x_next : width_lat;
    assign h_new = line_end ? sat_inc(y_cnt) : y_cnt;

    always_ff @(posedge iClk_0 or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_SEARCH: if (vs_rise) state_d = S_FRAME;
            S_FRAME:  state_d = S_FRAME;
            default:  state_d = S_SEARCH;
        endcase
    end

    always_ff @(posedge iClk_0 or negedge iRst_n) begin
        if (!iRst_n) begin
            phase     <= 1'b0;
            hold      <= '0;
            abort     <= 1'b0;
            x_next    <= '0;
            y_cnt     <= '0;
            width_lat <= '0;
        end else begin
            if (de_r) begin
                phase <= ~ph_eff;
                if (!ph_eff) hold <= d_r;
            end
            // Abort blanks the rest of the De window; next De rise rearms.
            if (abort_now) begin
                abort <= 1'b1;
            end else if (de_rise) begin
                abort <= 1'b0;
            end
            if (de_rise) begin
                x_next <= '0;
            end else if (emit) begin
                x_next <= sat_inc(x_next);
            end
            if (vs_rise) begin
                y_cnt <= '0;
            end else if (line_end) begin
                y_cnt <= sat_inc(y_cnt);
            end
            if (in_frame && de_fall) begin
                width_lat <= x_next;
            end
        end
    end

    always_ff @(posedge iClk_0 or negedge iRst_n) begin
        if (!iRst_n) begin
            pixel_q  <= '0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            valid_q <= emit;
            sof_q   <= emit && (x_next == '0) && (y_cnt == '0);
            if (emit) begin
                pixel_q <= {d_r, hold};
                x_q     <= x_next;
                y_q     <= y_cnt;
            end
            eol_q <= line_end;
            if (line_end && phase) begin
                error_q <= 1'b1;
            end
            if (meas) begin
                width_q  <= w_new;
                height_q <= h_new;
                if (w_new != width_q || h_new != height_q) begin
                    locked_q <= 1'b0;
                end else if (w_new != '0 && h_new != '0) begin
                    locked_q <= 1'b1;
                end
            end
        end
    end

    assign bus.oPixel       = pixel_q;
    assign bus.oPixelValid  = valid_q;
    assign bus.oX           = x_q;
    assign bus.oY           = y_q;
    assign bus.oSof         = sof_q;
    assign bus.oEol         = eol_q;
    assign bus.oLineWidth   = width_q;
    assign bus.oFrameHeight = height_q;
    assign bus.oLocked      = locked_q;
    assign bus.oError       = error_q;
endmodule

// File: tb/tb_dvi_in_capture.sv
// Testbench for dvi_in_capture: frame table plus reset/abort sequences.
// Pixels are predicted at drive time into a queue and popped on output.
module tb_dvi_in_capture;
    logic clk;
    logic rst_n;

    dvi_in_capture_if #(.CNT_W(12)) ifc ();

    dvi_in_capture #(
        .SYNC_ACT_HIGH(1'b1),
        .CNT_W(12)
    ) dut (
        .iClk_0(clk),
        .iRst_n(rst_n),
        .bus(ifc)
    );

    typedef struct {
        logic [23:0] pix;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
    } exp_t;

    typedef struct {
        int lines;
        int words;
        int exp_w;
        int exp_h;
        bit exp_lock;
        bit exp_err;
    } frame_vec_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks;
    int          n_pass;
    int          eol_cnt;
    int          valid_cnt;
    logic [11:0] word_v;
    logic [11:0] prev_w;
    frame_vec_t  fv[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {51'd0, ifc.oPixel, ifc.oPixelValid, ifc.oX, ifc.oY,
                ifc.oSof, ifc.oEol, ifc.oLineWidth, ifc.oFrameHeight,
                ifc.oLocked, ifc.oError};
    endfunction

    always @(negedge clk) begin
        if (ifc.oEol) eol_cnt++;
        if (ifc.oPixelValid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_pixel", ifc.oPixelValid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("pixel", {ifc.oSof, ifc.oY, ifc.oX, ifc.oPixel},
                      {e.sof, e.y, e.x, e.pix});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ifc.iDe    = 1'b0;
        ifc.iVsync = 1'b0;
        ifc.iData  = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vsync_pulse();
        ifc.iDe    = 1'b0;
        ifc.iVsync = 1'b1;
        tick();
        tick();
        idle(3);
    endtask

    task automatic rand_noise(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.iData  = 12'($urandom);
            ifc.iHsync = 1'($urandom);
            ifc.iDe    = 1'($urandom);
            ifc.iVsync = 1'b0;
            tick();
        end
    endtask

    // abort_at < 0: plain line; else vsync rises with word abort_at.
    task automatic run_line(input int nw, input int y, input int abort_at);
        exp_t x;
        for (int i = 0; i < nw; i++) begin
            ifc.iDe   = 1'b1;
            ifc.iData = word_v;
            if (abort_at >= 0 && i >= abort_at) ifc.iVsync = 1'b1;
            if ((i % 2 == 1) && (abort_at < 0 || i < abort_at)) begin
                x.pix = {word_v, prev_w};
                x.x   = 12'(i / 2);
                x.y   = 12'(y);
                x.sof = (i / 2 == 0) && (y == 0);
                sb.push_back(x);
            end
            prev_w = word_v;
            word_v = word_v + 12'd1;
            tick();
        end
        idle(6);
    endtask

    initial begin
        int e0;
        int v0;
        n_checks  = 0;
        n_pass    = 0;
        eol_cnt   = 0;
        valid_cnt = 0;
        word_v    = 12'h001;
        prev_w    = '0;

        fv[0] = '{2, 8, 4, 2, 1'b0, 1'b0};
        fv[1] = '{2, 8, 4, 2, 1'b1, 1'b0};
        fv[2] = '{2, 8, 4, 2, 1'b1, 1'b0};
        fv[3] = '{2, 10, 5, 2, 1'b0, 1'b0};
        fv[4] = '{1, 7, 3, 1, 1'b0, 1'b1};
        fv[5] = '{2, 8, 4, 2, 1'b0, 1'b1};
        fv[6] = '{2, 8, 4, 2, 1'b1, 1'b1};

        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifc.iData  = 12'($urandom);
            ifc.iHsync = 1'($urandom);
            ifc.iVsync = 1'($urandom);
            ifc.iDe    = 1'($urandom);
            tick();
            check("reset_outs", all_outs(), 128'd0);
        end
        ifc.iVsync = 1'b0;
        ifc.iDe    = 1'b0;
        tick();
        rst_n = 1'b1;
        v0 = valid_cnt;
        rand_noise(12);
        idle(4);
        check("no_pix_before_vsync", 32'(valid_cnt - v0), 32'd0);
        check("no_err_before_vsync", ifc.oError, 1'b0);

        vsync_pulse();
        for (int f = 0; f < 7; f++) begin
            e0 = eol_cnt;
            v0 = valid_cnt;
            for (int l = 0; l < fv[f].lines; l++) run_line(fv[f].words, l, -1);
            check("eol_count", 32'(eol_cnt - e0), 32'(fv[f].lines));
            check("pix_count", 32'(valid_cnt - v0),
                  32'(fv[f].lines * (fv[f].words / 2)));
            vsync_pulse();
            check("line_width", ifc.oLineWidth, 12'(fv[f].exp_w));
            check("frame_height", ifc.oFrameHeight, 12'(fv[f].exp_h));
            check("locked", ifc.oLocked, fv[f].exp_lock);
            check("error", ifc.oError, fv[f].exp_err);
            check("sb_empty", 32'(sb.size()), 32'd0);
        end

        e0 = eol_cnt;
        run_line(8, 0, -1);
        check("eol_before_abort", 32'(eol_cnt - e0), 32'd1);
        e0 = eol_cnt;
        v0 = valid_cnt;
        run_line(6, 1, 4);
        check("abort_no_eol", 32'(eol_cnt - e0), 32'd0);
        check("abort_pix", 32'(valid_cnt - v0), 32'd2);
        e0 = eol_cnt;
        run_line(8, 0, -1);
        check("after_abort_eol", 32'(eol_cnt - e0), 32'd1);
        check("sb_empty_abort", 32'(sb.size()), 32'd0);

        v0 = valid_cnt;
        ifc.iDe   = 1'b1;
        ifc.iData = word_v;
        tick();
        ifc.iData = word_v + 12'd1;
        tick();
        ifc.iData = word_v + 12'd2;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", all_outs(), 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold_outs", all_outs(), 128'd0);
        end
        word_v = word_v + 12'd3;
        ifc.iDe = 1'b0;
        rst_n = 1'b1;
        rand_noise(12);
        idle(4);
        check("no_pix_after_reset", 32'(valid_cnt - v0), 32'd0);
        check("err_cleared", ifc.oError, 1'b0);

        vsync_pulse();
        e0 = eol_cnt;
        v0 = valid_cnt;
        run_line(8, 0, -1);
        check("post_reset_pix", 32'(valid_cnt - v0), 32'd4);
        check("post_reset_eol", 32'(eol_cnt - e0), 32'd1);
        check("post_reset_lock", ifc.oLocked, 1'b0);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
